// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, captures the combinational
// instruction word and hands {pc, inst} pairs to decode through a 2-entry buffer.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              MEM_BYTES = 1024
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [XLEN-1:0] pc,
    input  logic [ILEN-1:0] inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            fault
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    // Last legal word address, widened by one bit so the range test cannot wrap.
    localparam logic [XLEN:0] LAST_PC = (XLEN+1)'(MEM_BYTES - 4);

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc_next;

    logic [XLEN-1:0] r_pc_q   [2];
    logic [ILEN-1:0] r_inst_q [2];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;

    logic            w_bad;
    logic            w_pop;
    logic            w_space;
    logic            w_push;

    assign w_bad   = (r_fetch_pc[1:0] != 2'b00) || ({1'b0, r_fetch_pc} > LAST_PC);
    assign w_pop   = out_valid && out_ready;
    assign w_space = (r_count < 2'd2) || w_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_push          = 1'b0;
        if (redirect_valid) begin
            w_state_next    = ST_FETCH;
            w_fetch_pc_next = redirect_pc;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_bad) begin
                        w_state_next = ST_FAULT;
                    end else if (w_space) begin
                        w_push          = 1'b1;
                        w_fetch_pc_next = r_fetch_pc + XLEN'(4);
                    end
                end
                ST_FAULT: begin
                    w_state_next = ST_FAULT;
                end
                default: begin
                    w_state_next = ST_FETCH;
                end
            endcase
        end
    end

    // A redirect flushes the buffer even when the head is popped the same cycle;
    // the popped instruction already belongs to decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the storage is reset too, so out_pc/out_inst read zero straight out of reset.
            for (int i = 0; i < 2; i++) begin
                r_pc_q[i]   <= '0;
                r_inst_q[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc_q[r_wr_ptr]   <= r_fetch_pc;
                r_inst_q[r_wr_ptr] <= inst;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign pc        = r_fetch_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = r_pc_q[r_rd_ptr];
    assign out_inst  = r_inst_q[r_rd_ptr];
    assign fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based model of the fetch stage is
// compared against the DUT after every clock edge, plus literal directed checks.
module tb_fetch_unit;

    localparam int MEM_BYTES = 1024;

    logic        clock;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;

    fetch_unit #(
        .XLEN(32), .ILEN(32), .RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pc(pc), .inst(inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .fault(fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem_words [256];
    assign inst = (pc < 32'(MEM_BYTES)) ? mem_words[pc[9:2]] : 32'hDEAD_BEEF;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_pc_q   [$];
    logic [31:0] m_inst_q [$];
    logic [31:0] m_fpc;
    bit          m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc_q.delete();
        m_inst_q.delete();
        m_fpc   = 32'h0;
        m_fault = 1'b0;
    endtask

    task automatic compare();
        check("out_valid", 32'(out_valid), 32'(m_pc_q.size() != 0));
        if (m_pc_q.size() != 0) begin
            check("out_pc", out_pc, m_pc_q[0]);
            check("out_inst", out_inst, m_inst_q[0]);
        end
        check("pc", pc, m_fpc);
        check("fault", 32'(fault), 32'(m_fault));
    endtask

    // Advance the model by one edge from the current inputs, clock, then compare.
    task automatic cycle();
        bit do_pop;
        bit has_space;
        do_pop    = (m_pc_q.size() != 0) && out_ready;
        has_space = (m_pc_q.size() < 2) || do_pop;
        if (redirect_valid) begin
            m_pc_q.delete();
            m_inst_q.delete();
            m_fpc   = redirect_pc;
            m_fault = 1'b0;
        end else begin
            if (do_pop) begin
                void'(m_pc_q.pop_front());
                void'(m_inst_q.pop_front());
            end
            if (!m_fault) begin
                if ((m_fpc % 4 != 0) || (longint'(m_fpc) + 4 > MEM_BYTES)) begin
                    m_fault = 1'b1;
                end else if (has_space) begin
                    m_pc_q.push_back(m_fpc);
                    m_inst_q.push_back(mem_words[m_fpc / 4]);
                    m_fpc = m_fpc + 4;
                end
            end
        end
        @(posedge clock);
        #1;
        compare();
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_pc", out_pc, 32'h0);
        check("rst out_inst", out_inst, 32'h0);
        check("rst pc", pc, 32'h0);
        check("rst fault", 32'(fault), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_target();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            6:       return {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            7:       return 32'h3F0 + 32'($urandom_range(0, 3)) * 4;
            8:       return $urandom | 32'h8000_0000;
            9:       return 32'h400;
            default: return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
        mem_words[0] = 32'h1111_1111;
        mem_words[1] = 32'h2222_2222;
        mem_words[2] = 32'h3333_3333;
        reset_n        = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();

        #12;
        check("init out_valid", 32'(out_valid), 32'h0);
        check("init out_pc", out_pc, 32'h0);
        check("init out_inst", out_inst, 32'h0);
        check("init pc", pc, 32'h0);
        check("init fault", 32'(fault), 32'h0);

        // Streaming from reset.
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("s1 valid", 32'(out_valid), 32'h1);
        check("s1 pc0", out_pc, 32'h0);
        check("s1 inst0", out_inst, 32'h1111_1111);
        check("s1 fetch pc", pc, 32'h4);
        cycle();
        check("s1 pc1", out_pc, 32'h4);
        check("s1 inst1", out_inst, 32'h2222_2222);
        cycle();
        check("s1 pc2", out_pc, 32'h8);
        check("s1 inst2", out_inst, 32'h3333_3333);
        check("s1 fetch pc2", pc, 32'hC);

        // Backpressure from reset: buffer fills, pc holds at 0x8.
        do_reset();
        out_ready = 1'b0;
        repeat (3) cycle();
        check("s2 pc hold", pc, 32'h8);
        check("s2 head pc", out_pc, 32'h0);
        check("s2 head inst", out_inst, 32'h1111_1111);
        out_ready = 1'b1;
        cycle();
        check("s2 drain1", out_pc, 32'h4);
        cycle();
        check("s2 drain2", out_pc, 32'h8);

        // Redirect while a handshake completes.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        check("s3 bubble", 32'(out_valid), 32'h0);
        redirect_valid = 1'b0;
        cycle();
        check("s3 target pc", out_pc, 32'h40);
        check("s3 target inst", out_inst, mem_words[16]);

        // Misaligned target faults, then recovery by redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        cycle();
        check("s4 fault late", 32'(fault), 32'h0);
        redirect_valid = 1'b0;
        cycle();
        check("s4 fault", 32'(fault), 32'h1);
        repeat (2) cycle();
        check("s4 pc frozen", pc, 32'h42);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cycle();
        check("s4 recovered", 32'(fault), 32'h0);
        redirect_valid = 1'b0;
        cycle();
        check("s4 resume", out_pc, 32'h0);

        // End of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F8;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("s5 first", out_pc, 32'h3F8);
        cycle();
        check("s5 last", out_pc, 32'h3FC);
        check("s5 pc end", pc, 32'h400);
        cycle();
        check("s5 fault", 32'(fault), 32'h1);
        repeat (2) cycle();

        // Async reset with a full buffer.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (4) cycle();
        check("s6 full valid", 32'(out_valid), 32'h1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            out_ready      = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = rand_target();
            cycle();
            if ($urandom_range(0, 999) < 4) begin
                redirect_valid = 1'b0;
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-issue RV core, directly upstream of the byte-addressed instruction memory. Holds the fetch PC, drives it to the instruction memory's `pc` input, captures the combinational `inst` word, and hands `{pc, inst}` pairs to decode through a 2-entry valid/ready buffer. Handles control-flow redirects with a buffer flush, and halts on misaligned or out-of-range fetch addresses.

## Interface
- `XLEN`, 32: address/PC width.
- `ILEN`, 32: instruction width.
- `RESET_PC`, 0: fetch PC loaded on reset.
- `MEM_BYTES`, 1024: instruction memory size in bytes; legal fetch requires `pc + 3 < MEM_BYTES`.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc` out XLEN: fetch address to instruction memory (registered).
- `inst` in ILEN: instruction word from instruction memory, combinational from `pc`.
- `redirect_valid` in 1: one-cycle redirect request from execute (branch/jump/trap).
- `redirect_pc` in XLEN: redirect target.
- `out_valid` out 1: buffer head valid to decode.
- `out_ready` in 1: decode accepts head this cycle.
- `out_inst` out ILEN: head instruction.
- `out_pc` out XLEN: head instruction address.
- `fault` out 1: fetch halted on illegal address.

## Operation
- State: `fetch_pc` register (drives `pc`), 2-entry FIFO of `{pc, inst}`, count 0..2, FSM {FETCH, FAULT}.
- `bad = (fetch_pc[1:0] != 0) || (fetch_pc > MEM_BYTES - 4)` (compare in XLEN+1 bits; no wrap).
- `pop = out_valid && out_ready`. `space = (count < 2) || pop`.
- Priority per cycle, highest first:
  - `redirect_valid`: FIFO flushed (count <= 0, regardless of pop), `fetch_pc <= redirect_pc`, FSM <= FETCH, no push. Target legality is checked from the next cycle.
  - FETCH and `bad`: FSM <= FAULT, no push, `fetch_pc` holds.
  - FETCH, `!bad`, `space`: push `{fetch_pc, inst}`, `fetch_pc <= fetch_pc + 4`.
  - FETCH, `!space`: hold; `fetch_pc` unchanged (memory re-read next cycle).
  - FAULT: no push, `fetch_pc` holds; FIFO continues to drain via pop.
- FIFO order strictly preserved; simultaneous push and pop with count 2 legal (count stays 2).
- `out_valid = (count != 0)`; `out_inst/out_pc` = head entry, stable while `out_valid && !out_ready`.
- `fault = (FSM == FAULT)`. Only a redirect or reset leaves FAULT.

## Timing
- Reset (async, immediate): `fetch_pc = RESET_PC`, count 0, FSM FETCH, `out_valid = 0`, `out_inst = 0`, `out_pc = 0`, `fault = 0`; FIFO storage cleared.
- First rising edge with `reset_n` high pushes `RESET_PC`; `out_valid` high after that edge.
- Steady state, `out_ready` held 1: one instruction per cycle, zero bubbles.
- Redirect sampled at edge N: `out_valid = 0` after N; target instruction presented after N+1 (1 bubble).
- Redirect in the same cycle as a pop: handshake completes (decode owns the popped instruction), remaining entries flushed.
- Illegal address at edge N: `fault = 1` after N; remaining entries still delivered.
- `reset_n` asserted mid-stream: all state cleared without a clock edge; no partial handshake survives.

## Test plan
- Memory preloaded with 0x11111111@0, 0x22222222@4, 0x33333333@8, reset release, `out_ready = 1` -> consecutive cycles present (0x0, 0x11111111), (0x4, 0x22222222), (0x8, 0x33333333); `pc` advances by 4 each cycle.
- `out_ready = 0` from reset -> count reaches 2, `pc` holds at 0x8, head stays (0x0, 0x11111111); release -> 0x0, 0x4, 0x8 in order, none lost or duplicated.
- Streaming, redirect to 0x40 while `out_valid && out_ready` -> `out_valid = 0` next cycle, then `out_pc = 0x40` with `out_inst = mem word @0x40`.
- Redirect to 0x42 -> `fault = 1` one cycle after the target loads, `out_valid = 0` after drain, `pc` frozen at 0x42; redirect to 0x0 -> `fault = 0`, fetch resumes at 0x0.
- Redirect to 0x3F8, `out_ready = 1` -> 0x3F8 and 0x3FC delivered, `pc = 0x400`, `fault = 1`, no further pushes.
- `reset_n` low asynchronously between edges with count 2 -> `out_valid = 0`, `out_pc = 0`, `out_inst = 0`, `pc = RESET_PC`, `fault = 0` immediately.
